// File: rtl/spi_cfg_regfile.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_regfile
// Brief    : SPI mode-0 slave loading shadow config registers, committed to
//            the active bank atomically at frame end. Optional macro:
//            SPI_CFG_PARITY_EN (even-parity bit after every data word).
// Revision : 1.0
// ============================================================================
module spi_cfg_regfile #(
    parameter int NREG        = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   sck,
    input  logic                   mosi,
    input  logic                   nss,
    output logic [NREG*DATA_W-1:0] cfg,
    output logic                   trig,
    output logic                   progn,
    output logic                   commit,
    output logic                   err
);

`ifdef SPI_CFG_PARITY_EN
    localparam int c_word_bits = DATA_W + 1;
`else
    localparam int c_word_bits = DATA_W;
`endif
    // Shift register only holds the bits that precede the one sampled live.
    localparam int c_sr_w = (c_word_bits - 1 > 7) ? c_word_bits - 1 : 7;

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_hdr    = 2'd1;
    localparam logic [1:0] c_data   = 2'd2;
    localparam logic [1:0] c_commit = 2'd3;

    logic [SYNC_STAGES-1:0]  sck_sync_q, mosi_sync_q, nss_sync_q;
    logic                    sck_prev_q, nss_prev_q;
    logic [1:0]              state_q, state_d;
    logic [4:0]              cnt_q;
    logic [c_sr_w-1:0]       sr_q;
    logic [6:0]              addr_q;
    logic                    ptrig_q;
    logic                    wr_flag_q;
    logic [NREG*DATA_W-1:0]  shadow_q;
    logic [NREG*DATA_W-1:0]  cfg_q;
    logic                    trig_q;

    logic              w_sck_s, w_nss_s, w_mosi;
    logic              w_sck_rise, w_nss_rise, w_nss_fall;
    logic              w_bit, w_hdr_end, w_word_end, w_word_ok, w_in_range, w_wr_en;
    logic [DATA_W-1:0] w_word;
    logic [6:0]        w_addr_nxt;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            nss_sync_q  <= '1;
            sck_prev_q  <= 1'b0;
            nss_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], nss};
            sck_prev_q  <= w_sck_s;
            nss_prev_q  <= w_nss_s;
        end
    end

    assign w_sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign w_nss_s    = nss_sync_q[SYNC_STAGES-1];
    assign w_mosi     = mosi_sync_q[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~sck_prev_q;
    assign w_nss_rise = w_nss_s & ~nss_prev_q;
    assign w_nss_fall = ~w_nss_s & nss_prev_q;

    // Frame end takes priority over a coincident sck edge.
    assign w_bit      = w_sck_rise & ~w_nss_rise;
    assign w_hdr_end  = (state_q == c_hdr) && w_bit && (cnt_q == 5'd7);
    assign w_word_end = (state_q == c_data) && w_bit && (cnt_q == 5'(c_word_bits - 1));

`ifdef SPI_CFG_PARITY_EN
    assign w_word    = sr_q[DATA_W-1:0];
    assign w_word_ok = ~(^{w_word, w_mosi});
`else
    assign w_word    = {sr_q[DATA_W-2:0], w_mosi};
    assign w_word_ok = 1'b1;
`endif

    assign w_in_range = ({1'b0, addr_q} < 8'(NREG));
    assign w_wr_en    = w_word_end & w_word_ok & w_in_range;
    assign w_addr_nxt = (addr_q == 7'(NREG - 1)) ? 7'd0 : addr_q + 7'd1;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state_q <= c_idle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:   if (w_nss_fall) state_d = c_hdr;
            c_hdr: begin
                if (w_nss_rise)     state_d = c_idle;
                else if (w_hdr_end) state_d = c_data;
            end
            c_data:   if (w_nss_rise) state_d = wr_flag_q ? c_commit : c_idle;
            c_commit: state_d = c_idle;
            default:  state_d = c_idle;
        endcase
    end

    always_comb begin
        progn  = 1'b1;
        commit = 1'b0;
        case (state_q)
            c_hdr, c_data: progn  = 1'b0;
            c_commit:      commit = 1'b1;
            default:       progn  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q     <= '0;
            sr_q      <= '0;
            addr_q    <= '0;
            ptrig_q   <= 1'b0;
            wr_flag_q <= 1'b0;
            shadow_q  <= '0;
            cfg_q     <= '0;
            trig_q    <= 1'b0;
        end else begin
            case (state_q)
                c_idle: begin
                    if (w_nss_fall) begin
                        cnt_q     <= '0;
                        wr_flag_q <= 1'b0;
                    end
                end
                c_hdr: begin
                    if (w_bit) begin
                        sr_q <= {sr_q[c_sr_w-2:0], w_mosi};
                        if (w_hdr_end) begin
                            cnt_q   <= '0;
                            addr_q  <= {sr_q[5:0], w_mosi};
                            ptrig_q <= sr_q[6];
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                c_data: begin
                    if (w_bit) begin
                        sr_q <= {sr_q[c_sr_w-2:0], w_mosi};
                        if (w_word_end) begin
                            cnt_q  <= '0;
                            addr_q <= w_addr_nxt;
                            if (w_word_ok) wr_flag_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                c_commit: begin
                    cfg_q  <= shadow_q;
                    trig_q <= ptrig_q;
                end
                default: cnt_q <= '0;
            endcase

            for (int i = 0; i < NREG; i++) begin
                if (w_wr_en && (addr_q == 7'(i)))
                    shadow_q[i*DATA_W +: DATA_W] <= w_word;
            end
        end
    end

`ifdef SPI_CFG_PARITY_EN
    logic err_q;
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)                       err_q <= 1'b0;
        else if (w_word_end && !w_word_ok) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cfg  = cfg_q;
    assign trig = trig_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_cfg_regfile
// Brief    : Scoreboard bench for spi_cfg_regfile (NREG=8, DATA_W=8).
// Revision : 1.0
// ============================================================================
module tb_spi_cfg_regfile;
    localparam int NREG = 8;
    localparam int DW   = 8;
    localparam int CW   = NREG * DW;

    typedef struct {
        logic [CW-1:0] cfg;
        logic          trig;
    } exp_t;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic          nss = 1'b1;
    logic [CW-1:0] cfg;
    logic          trig, progn, commit, err;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    spi_cfg_regfile #(.NREG(NREG), .DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .arstn  (arstn),
        .sck    (sck),
        .mosi   (mosi),
        .nss    (nss),
        .cfg    (cfg),
        .trig   (trig),
        .progn  (progn),
        .commit (commit),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic sck_bit(input logic b);
        @(negedge clk) mosi = b;
        repeat (3) @(negedge clk);
        sck = 1'b1;
        repeat (3) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sck_bit(b[i]);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) sck_bit(w[i]);
`ifdef SPI_CFG_PARITY_EN
        sck_bit(^w);
`endif
    endtask

    task automatic frame_begin();
        @(negedge clk) nss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (2) @(negedge clk);
        nss = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic push_exp(input logic [CW-1:0] c, input logic t);
        exp_t e;
        e.cfg  = c;
        e.trig = t;
        exp_q.push_back(e);
    endtask

    // Monitor: every commit pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (commit) begin
                chk("progn_at_commit", CW'(progn), CW'(1'b1));
                @(negedge clk);
                chk("commit_width", CW'(commit), CW'(1'b0));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: got commit with cfg %h, required no commit", cfg);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_cfg", cfg, e.cfg);
                    chk("commit_trig", CW'(trig), CW'(e.trig));
                end
            end
        end
    end

    initial begin
        int wait_cnt;

        // Reset held while the SPI pins wiggle.
        nss = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) sck = ~sck;
            repeat (2) @(negedge clk);
        end
        sck = 1'b0;
        nss = 1'b1;
        chk("rst_cfg", cfg, '0);
        chk("rst_trig", CW'(trig), '0);
        chk("rst_progn", CW'(progn), CW'(1'b1));
        chk("rst_commit", CW'(commit), '0);
        chk("rst_err", CW'(err), '0);
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        repeat (4) @(negedge clk);

        frame_begin();
        send_byte(8'h82);
        chk("progn_in_frame", CW'(progn), '0);
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        chk("progn_late_frame", CW'(progn), '0);
        push_exp(64'h0000003322110000, 1'b1);
        frame_end();

        frame_begin();
        send_byte(8'h07);
        send_word(8'hAA);
        send_word(8'hBB);
        push_exp(64'hAA000033221100BB, 1'b0);
        frame_end();

        frame_begin();
        send_byte(8'h0A);
        send_word(8'h55);
        push_exp(64'hAA000033221100BB, 1'b0);
        frame_end();

        // Abort: partial word, no commit expected.
        frame_begin();
        send_byte(8'h81);
        for (int i = 0; i < 5; i++) sck_bit(1'b1);
        frame_end();
        chk("abort_cfg", cfg, 64'hAA000033221100BB);
        chk("abort_trig", CW'(trig), '0);
        chk("abort_progn", CW'(progn), CW'(1'b1));

        frame_begin();
        send_byte(8'h01);
        send_word(8'h5C);
        push_exp(64'hAA00003322115CBB, 1'b0);
        frame_end();

        // Header-only frame must not commit.
        frame_begin();
        send_byte(8'h85);
        frame_end();
        chk("hdr_only_trig", CW'(trig), '0);
        chk("hdr_only_cfg", cfg, 64'hAA00003322115CBB);

        frame_begin();
        send_byte(8'h80);
        send_word(8'h01);
        push_exp(64'hAA00003322115C01, 1'b1);
        frame_end();
        chk("no_err_default", CW'(err), '0);

        // Reset in the middle of a frame clears everything at once.
        frame_begin();
        send_byte(8'h83);
        sck_bit(1'b1);
        @(negedge clk) arstn = 1'b0;
        #1;
        chk("midrst_cfg", cfg, '0);
        chk("midrst_trig", CW'(trig), '0);
        chk("midrst_progn", CW'(progn), CW'(1'b1));
        nss = 1'b1;
        sck = 1'b0;
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        repeat (4) @(negedge clk);

`ifdef SPI_CFG_PARITY_EN
        frame_begin();
        send_byte(8'h00);
        for (int i = DW - 1; i >= 0; i--) sck_bit(DW'(8'h0F) >> i);
        sck_bit(1'b0);
        for (int i = DW - 1; i >= 0; i--) sck_bit(DW'(8'h01) >> i);
        sck_bit(1'b0);
        push_exp(64'h000000000000000F, 1'b0);
        frame_end();
        chk("parity_err_set", CW'(err), CW'(1'b1));

        frame_begin();
        send_byte(8'h02);
        send_word(8'h03);
        push_exp(64'h000000000003000F, 1'b0);
        frame_end();
        chk("parity_err_sticky", CW'(err), CW'(1'b1));
`endif

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_commit: got %0d outstanding, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
